// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with a pipeline interlock that holds HI/LO-class instructions while a sequence runs.
module muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [5:0]  i_func,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hilo_rdata,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    localparam logic [5:0] F_MFHI = 6'b010000;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t      state_reg;
    logic [5:0]  cnt_reg;
    logic [63:0] acc_reg;
    logic [31:0] opnd_reg;
    logic [31:0] hi_reg, lo_reg;
    logic        busy_reg, done_reg;
    logic        is_div_reg, neg_q_reg, neg_r_reg, div0_reg;

    logic        op_signed, is_muldiv, is_move, accept;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] acc_step, prod_fix;
    logic [31:0] quo_fix, rem_fix, fix_hi, fix_lo;

    assign o_stall      = i_start & busy_reg;
    assign o_busy       = busy_reg;
    assign o_done       = done_reg;
    assign o_hi         = hi_reg;
    assign o_lo         = lo_reg;
    assign o_hilo_rdata = (i_func == F_MFHI) ? hi_reg : lo_reg;

    assign op_signed = ~i_func[0];
    assign is_muldiv = (i_func[5:2] == 4'b0110);
    assign is_move   = (i_func[5:2] == 4'b0100);
    assign accept    = (state_reg == S_IDLE) && i_start && !o_stall && !i_flush;

    always_comb begin
        rs_mag = (op_signed && i_rs_data[31]) ? -i_rs_data : i_rs_data;
        rt_mag = (op_signed && i_rt_data[31]) ? -i_rt_data : i_rt_data;

        // Multiply: add multiplicand into the upper half on a 1 multiplier bit, then shift right.
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        // Divide: acc holds {remainder, dividend}; shift one dividend bit in and trial-subtract.
        div_shift = acc_reg[63:31];
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_rem   = div_ge ? div_diff[31:0] : div_shift[31:0];
        acc_step  = is_div_reg ? {div_rem, acc_reg[30:0], div_ge} : {mul_sum, acc_reg[31:1]};

        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quo_fix  = div0_reg ? 32'hFFFF_FFFF : (neg_q_reg ? -acc_reg[31:0] : acc_reg[31:0]);
        // A zero divisor leaves |rs| as remainder, so the sign fix restores the original rs.
        rem_fix  = neg_r_reg ? -acc_reg[63:32] : acc_reg[63:32];
        fix_hi   = is_div_reg ? rem_fix : prod_fix[63:32];
        fix_lo   = is_div_reg ? quo_fix : prod_fix[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept && is_muldiv) begin
                        is_div_reg <= i_func[1];
                        neg_q_reg  <= op_signed && (i_rs_data[31] ^ i_rt_data[31]);
                        neg_r_reg  <= op_signed && i_rs_data[31];
                        div0_reg   <= i_func[1] && (i_rt_data == 32'd0);
                        if (i_func[1]) begin
                            acc_reg  <= {32'd0, rs_mag};
                            opnd_reg <= rt_mag;
                        end else begin
                            acc_reg  <= {32'd0, rt_mag};
                            opnd_reg <= rs_mag;
                        end
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_ITER;
                    end else if (accept && is_move && i_func[0]) begin
                        if (i_func[1]) lo_reg <= i_rs_data;
                        else           hi_reg <= i_rs_data;
                    end
                end
                S_ITER: begin
                    if (i_flush) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        acc_reg <= acc_step;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == 6'(ITER - 1)) state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                    if (!i_flush) begin
                        hi_reg   <= fix_hi;
                        lo_reg   <= fix_lo;
                        done_reg <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, timing, interlock and abort paths.
module tb_muldiv_sequencer;
    localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000, F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010, F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [5:0]  i_func = '0;
    logic [31:0] i_rs_data = '0;
    logic [31:0] i_rt_data = '0;
    logic        i_flush = 1'b0;
    logic        o_stall, o_busy, o_done;
    logic [31:0] o_hilo_rdata, o_hi, o_lo;

    int vectors = 0;
    int miscompares = 0;

    muldiv_sequencer #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_func(i_func),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_flush(i_flush),
        .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done),
        .o_hilo_rdata(o_hilo_rdata), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one MULT/DIV, check busy window, done pulse and the final HI/LO.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        i_start = 1'b1; i_func = f; i_rs_data = rs; i_rt_data = rt;
        tick();
        i_start = 1'b0; i_func = F_ADD;
        check({tag, " busy_c1"}, 32'(o_busy), 32'd1);
        repeat (32) tick();
        check({tag, " busy_c33"}, 32'({o_busy, o_done}), 32'b10);
        tick();
        check({tag, " c34_busy_done"}, 32'({o_busy, o_done}), 32'b01);
        check({tag, " hi"}, o_hi, exp_hi);
        check({tag, " lo"}, o_lo, exp_lo);
        tick();
        check({tag, " done_c35"}, 32'(o_done), 32'd0);
        $display("op %s rs=%h rt=%h -> hi=%h lo=%h", tag, rs, rt, o_hi, o_lo);
    endtask

    initial begin
        logic saw_done;
        logic stall_all;

        repeat (2) tick();
        reset = 1'b0;
        i_start = 1'b1; i_func = F_MFLO;
        #1;
        check("reset rdata", o_hilo_rdata, 32'd0);
        check("reset stall", 32'(o_stall), 32'd0);
        check("reset busy_done", 32'({o_busy, o_done}), 32'd0);
        check("reset hi", o_hi, 32'd0);
        check("reset lo", o_lo, 32'd0);
        tick();
        i_start = 1'b0;

        run_op("MULT",  F_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("MULTU", F_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("DIV",   F_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("DIVU",  F_DIVU,  32'd100,       32'd7, 32'd2,         32'd14);
        run_op("DIV0",  F_DIV,   32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("DIVOV", F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Interlock: MFLO held from cycle 1 stalls through cycle 33.
        i_start = 1'b1; i_func = F_MULT; i_rs_data = 32'd5; i_rt_data = 32'd6;
        tick();
        i_func = F_MFLO;
        stall_all = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            stall_all &= o_stall;
            if (c == 15) begin
                i_start = 1'b0; i_func = F_ADD;
                #1;
                check("add no stall", 32'(o_stall), 32'd0);
                i_start = 1'b1; i_func = F_MFLO;
                #1;
            end
            tick();
        end
        check("stall c1..c33", 32'(stall_all), 32'd1);
        check("stall c34", 32'(o_stall), 32'd0);
        check("mflo c34", o_hilo_rdata, 32'd30);
        $display("interlock mult 5x6 -> mflo=%h", o_hilo_rdata);
        tick();
        i_start = 1'b0;

        // MTLO then MFLO next cycle, restore LO to 30 afterwards via the same path.
        i_start = 1'b1; i_func = F_MTLO; i_rs_data = 32'h0000_0055;
        tick();
        i_func = F_MFLO;
        #1;
        check("mtlo readback", o_hilo_rdata, 32'h0000_0055);
        i_func = F_MTLO; i_rs_data = 32'd30;
        tick();

        // Flush abort.
        i_func = F_MTHI; i_rs_data = 32'hAAAA_AAAA;
        tick();
        i_func = F_MFHI;
        #1;
        check("mthi readback", o_hilo_rdata, 32'hAAAA_AAAA);
        i_func = F_DIV; i_rs_data = 32'd9; i_rt_data = 32'd3;
        tick();
        i_start = 1'b0; i_func = F_ADD;
        repeat (9) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush busy c11", 32'(o_busy), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            saw_done |= o_done;
            tick();
        end
        check("flush no done", 32'(saw_done), 32'd0);
        check("flush hi", o_hi, 32'hAAAA_AAAA);
        check("flush lo", o_lo, 32'd30);
        $display("flush div 9/3 -> hi=%h lo=%h", o_hi, o_lo);

        // Reset abort in cycle 20.
        i_start = 1'b1; i_func = F_DIV; i_rs_data = 32'd9; i_rt_data = 32'd3;
        tick();
        i_start = 1'b0; i_func = F_ADD;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset-abort busy", 32'(o_busy), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            saw_done |= o_done;
            tick();
        end
        check("reset-abort no done", 32'(saw_done), 32'd0);
        check("reset-abort hi", o_hi, 32'd0);
        check("reset-abort lo", o_lo, 32'd0);
        $display("reset abort div 9/3 -> hi=%h lo=%h", o_hi, o_lo);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
